icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the core's instruction-fetch port and the system memory bus.
- On a hit it returns the instruction word combinationally, with the same timing as a plain imem.
- On a miss it raises cpu_stall and fills the whole line from memory, one word at a time, over a req/ready + rvalid bus.
- It provides an invalidate-all input for FENCE.I and a saturating miss counter for the CSR/perf path.

---
 rtl/icache_dm.sv | 136 +++++++++++++
 tb/tb_icache_dm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache sitting between the fetch stage and the
// memory bus. Hits return data combinationally; misses refill the whole line in word order.
module icache_dm #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] miss_cnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state;
    logic [31:0]        data_arr [0:NUM_LINES-1][0:LINE_WORDS-1];
    logic [TAG_W-1:0]   tag_arr  [0:NUM_LINES-1];
    logic [NUM_LINES-1:0] valid;

    logic [TAG_W-1:0]   fill_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [WORD_W-1:0]  wcnt;
    logic               abort;

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [WORD_W-1:0]  addr_word;
    logic               hit;
    logic               take_miss;
    logic               last_word;
    logic               unused_addr_bits;

    assign addr_tag  = cpu_addr[31:IDX_W+OFF_W];
    assign addr_idx  = cpu_addr[IDX_W+OFF_W-1:OFF_W];
    assign addr_word = cpu_addr[OFF_W-1:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit       = cpu_req & valid[addr_idx] & (tag_arr[addr_idx] == addr_tag);
    assign take_miss = (state == IDLE) & cpu_req & ~hit & ~flush;
    assign last_word = (wcnt == WORD_W'(LINE_WORDS - 1));

    // Stall is forced low while in reset so the core is not held by stale lookups.
    always_comb begin
        cpu_rd_data = NOP;
        cpu_stall   = 1'b1;
        if (state == IDLE) begin
            cpu_rd_data = data_arr[addr_idx][addr_word];
            cpu_stall   = cpu_req & ~hit;
        end
        if (rst) begin
            cpu_stall = 1'b0;
        end
    end

    assign mem_req  = (state == REQ);
    assign mem_addr = mem_req ? {fill_tag, fill_idx, wcnt, 2'b00} : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            wcnt     <= '0;
            abort    <= 1'b0;
            miss_cnt <= 32'h0;
            fill_tag <= '0;
            fill_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_miss) begin
                        fill_tag <= addr_tag;
                        fill_idx <= addr_idx;
                        wcnt     <= '0;
                        abort    <= 1'b0;
                        if (miss_cnt != 32'hFFFF_FFFF) begin
                            miss_cnt <= miss_cnt + 32'h1;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (last_word) begin
                            state <= DONE;
                        end else begin
                            wcnt  <= wcnt + WORD_W'(1);
                            state <= REQ;
                        end
                    end
                end
                DONE: begin
                    valid[fill_idx] <= ~abort & ~flush;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Flush overrides any valid bit set above; an in-flight fill is marked aborted.
            if (flush) begin
                valid <= '0;
                if (state != IDLE) begin
                    abort <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == WAIT && mem_rvalid) begin
            data_arr[fill_idx][wcnt] <= mem_rdata;
        end
        if (state == DONE) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: expected bus addresses and fetch data are queued when a
// fetch is issued and compared as the bus model and the fetch port produce them.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rd_data;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] miss_cnt;

    int assert_count = 0;
    int fail_count   = 0;
    int ready_delay  = 0;
    int rvalid_delay = 0;
    int accept_count = 0;
    bit pending      = 1'b0;
    logic [31:0] miss_exp = 32'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    icache_dm dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rd_data(cpu_rd_data),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Memory model returns data equal to the word address; delays are set per test.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            int ready_cnt;
            int rv_cnt;
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (pending) begin
                if (rv_cnt < rvalid_delay) begin
                    rv_cnt++;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = req_addr;
                    pending    = 1'b0;
                end
            end else if (mem_req) begin
                if (ready_cnt == 0) begin
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("unexpected_req", {31'b0, mem_req}, 32'h0);
                        req_addr = mem_addr;
                    end else begin
                        req_addr = exp_addr_q.pop_front();
                        checkOutput("mem_addr", mem_addr, req_addr);
                    end
                end else begin
                    checkOutput("addr_stable", mem_addr, req_addr);
                end
                if (ready_cnt < ready_delay) begin
                    ready_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    ready_cnt = 0;
                    rv_cnt    = 0;
                    pending   = 1'b1;
                    accept_count++;
                end
            end
        end
    end

    // One fetch: queue its expected refill addresses and data, then wait out the stall.
    task automatic applyStimulus(input logic [31:0] addr, input int n_fills, input int exp_stall);
        int stalls;
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        for (int f = 0; f < n_fills; f++) begin
            for (int w = 0; w < 4; w++) begin
                exp_addr_q.push_back(base + 32'(w * 4));
            end
        end
        exp_data_q.push_back({addr[31:2], 2'b00});
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        stalls   = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 400) begin
            stalls++;
            if (stalls == 2) begin
                checkOutput("nop_data", cpu_rd_data, 32'h0000_0013);
            end
            @(negedge clk);
        end
        checkOutput("stall_cycles", 32'(stalls), 32'(exp_stall));
        checkOutput("rd_data", cpu_rd_data, exp_data_q.pop_front());
        miss_exp = miss_exp + 32'(n_fills);
        checkOutput("miss_cnt", miss_cnt, miss_exp);
    endtask

    initial begin
        int n;
        int target;
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = 32'h0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0104;
        #1;
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("rst_miss_cnt", miss_cnt, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] cold miss and hits");
        applyStimulus(32'h0000_0104, 1, 10);
        applyStimulus(32'h0000_0100, 0, 0);
        applyStimulus(32'h0000_0108, 0, 0);
        applyStimulus(32'h0000_010C, 0, 0);

        $display("[TB] conflict eviction");
        applyStimulus(32'h0000_0500, 1, 10);
        applyStimulus(32'h0000_0100, 1, 10);
        applyStimulus(32'h0000_0504, 1, 10);

        $display("[TB] bus backpressure");
        ready_delay  = 5;
        rvalid_delay = 3;
        applyStimulus(32'h0000_0648, 1, 2 + 4 * (5 + 1 + 3 + 1));
        ready_delay  = 0;
        rvalid_delay = 0;
        applyStimulus(32'h0000_064C, 0, 0);
        applyStimulus(32'h0000_0640, 0, 0);

        $display("[TB] flush mid-fill");
        target = accept_count + 2;
        fork
            applyStimulus(32'h0000_0208, 2, 20);
            begin
                n = 0;
                while (accept_count < target && n < 200) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        join
        applyStimulus(32'h0000_0204, 0, 0);
        applyStimulus(32'h0000_0648, 1, 10);

        $display("[TB] reset mid-fill");
        rvalid_delay = 8;
        target = accept_count + 1;
        for (int w = 0; w < 4; w++) begin
            exp_addr_q.push_back(32'h0000_0300 + 32'(w * 4));
        end
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0300;
        n = 0;
        while (accept_count < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("fill_accepted", 32'(accept_count), 32'(target));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("midrst_mem_addr", mem_addr, 32'h0);
        checkOutput("midrst_stall", {31'b0, cpu_stall}, 32'h0);
        checkOutput("midrst_miss_cnt", miss_cnt, 32'h0);
        cpu_req = 1'b0;
        exp_addr_q.delete();
        miss_exp = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (pending && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("late_rvalid_seen", {31'b0, pending}, 32'h0);
        @(negedge clk);
        checkOutput("late_rvalid_idle", {31'b0, mem_req}, 32'h0);
        checkOutput("late_rvalid_cnt", miss_cnt, 32'h0);
        rvalid_delay = 0;
        applyStimulus(32'h0000_0300, 1, 10);
        applyStimulus(32'h0000_030C, 0, 0);

        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        checkOutput("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
